// File: rtl/gcd_pkg.sv
// Shared types and sizing helpers for the binary GCD engine.
package gcd_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REDUCE = 1'b1
    } gcd_state_t;

    // k counts common factors of two; it can reach WIDTH-1.
    function automatic int k_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_step.sv
// One Stein reduction step: applies the first matching rule to (u, v, k).
module gcd_step #(
    parameter int WIDTH = 8,
    parameter int KW    = 4
) (
    input  logic [WIDTH-1:0] u_i,
    input  logic [WIDTH-1:0] v_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] u_o,
    output logic [WIDTH-1:0] v_o,
    output logic [KW-1:0]    k_o,
    output logic             term_o,
    output logic [WIDTH-1:0] r_o
);

    always_comb begin
        u_o    = u_i;
        v_o    = v_i;
        k_o    = k_i;
        term_o = 1'b0;
        r_o    = (u_i == '0) ? v_i : u_i;

        if (u_i == v_i || u_i == '0 || v_i == '0) begin
            term_o = 1'b1;
        end else if (!u_i[0] && !v_i[0]) begin
            u_o = u_i >> 1;
            v_o = v_i >> 1;
            k_o = k_i + KW'(1);
        end else if (!u_i[0]) begin
            u_o = u_i >> 1;
        end else if (!v_i[0]) begin
            v_o = v_i >> 1;
        end else if (u_i >= v_i) begin
            // odd - odd is even, so the halving never drops a set bit
            u_o = (u_i - v_i) >> 1;
        end else begin
            v_o = (v_i - u_i) >> 1;
        end
    end

endmodule

// File: rtl/binary_gcd.sv
// Handshaked iterative binary GCD: one reduction step per clock, done pulse on completion.
module binary_gcd
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ans
);

    localparam int KW = k_width(WIDTH);

    gcd_state_t       state_q, state_d;
    logic [WIDTH-1:0] u_q, u_d, v_q, v_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] ans_q, ans_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] u_nx, v_nx, r_nx;
    logic [KW-1:0]    k_nx;
    logic             term;

    gcd_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
        .u_i    (u_q),
        .v_i    (v_q),
        .k_i    (k_q),
        .u_o    (u_nx),
        .v_o    (v_nx),
        .k_o    (k_nx),
        .term_o (term),
        .r_o    (r_nx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            u_q     <= '0;
            v_q     <= '0;
            k_q     <= '0;
            ans_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            k_q     <= k_d;
            ans_q   <= ans_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        k_d     = k_q;
        ans_d   = ans_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    u_d     = a;
                    v_d     = b;
                    k_d     = '0;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                if (term) begin
                    // restoring the common factor of two always fits in WIDTH
                    ans_d   = r_nx << k_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    u_d = u_nx;
                    v_d = v_nx;
                    k_d = k_nx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == REDUCE);
        done = done_q;
        ans  = ans_q;
    end

endmodule

// File: doc/binary_gcd.md
# binary_gcd

- Parametrised, iterative binary (Stein) GCD engine.
- Takes two unsigned WIDTH-bit operands on a start pulse and performs one reduction step per clock.
- Returns gcd(a, b) with a single-cycle done pulse; busy flags the engine while it works.
- Replaces the fixed 8-bit, free-running gcd datapath with a handshaked, width-generic unit usable by any arithmetic front end in the design.

## Interface

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is WIDTH ≥ 2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- a  in  WIDTH  first operand, unsigned; sampled with start.
- b  in  WIDTH  second operand, unsigned; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse when ans is updated.
- ans  out  WIDTH  result; holds its value until the next completion.

## Operation

- Working registers: u, v (WIDTH bits each) and shift count k ($clog2(WIDTH)+1 bits).
- The state machine has two states, IDLE and REDUCE.
- IDLE:
  - If start=1: load u←a, v←b, k←0, then go to REDUCE.
  - Otherwise hold.
- REDUCE: each cycle applies exactly one rule, taking the first that matches.
  1. Terminate, when u==v, u==0 or v==0. Select r = (u==0 ? v : u). Write ans←r<<k (truncated to WIDTH bits; the result always fits), pulse done, go to IDLE.
  2. Both even: u←u>>1, v←v>>1, k←k+1.
  3. u even only: u←u>>1.
  4. v even only: v←v>>1.
  5. Both odd: if u≥v then u←(u−v)>>1, else v←(v−u)>>1.
- Zero cases: gcd(x,0)=gcd(0,x)=x and gcd(0,0)=0.
- start asserted while busy=1 is ignored. There is no queueing and no error flag.
- start asserted in the same cycle that done is high is accepted, because the state is already IDLE.
- Reset mid-operation aborts the operation: state←IDLE, busy←0, done←0, ans←0. Any partial result is discarded.

## Timing

- Reset values: busy=0, done=0, ans=0, state=IDLE.
- Let the start cycle be cycle 0, and let N be the number of non-terminating REDUCE steps.
  - busy is high in cycles 1..N+1.
  - done is high in cycle N+2 only.
  - ans is valid from cycle N+2 onward.
- Bound: N ≤ 2·WIDTH, since each step removes at least one bit from u or v. Worst-case latency is therefore 2·WIDTH+2 cycles.
- done and busy are never high in the same cycle.
- ans changes only on the terminating edge or on reset.

## Structure

- Shared package gcd_pkg contains:
  - typedef enum gcd_state_t {IDLE, REDUCE};
  - the function computing the k width from WIDTH.
- One combinational sub-module, gcd_step, is natural.
  - Inputs: u, v, k.
  - Outputs: next u, v, k, a terminate flag and r.
  - This isolates the rule priority so it can be unit-tested.
- The top level holds the FSM, the registers and the final left shift.

## Test plan

- WIDTH=8, a=12, b=18, start at cycle 0:
  - expected steps (6,9,k=1) → (3,9) → (3,3), so N=3;
  - done only in cycle 5, ans=6;
  - busy high in cycles 1–4.
- a=0, b=0: done in cycle 2, ans=0. Then a=0, b=45: ans=45, done in cycle 2.
- a=255, b=1: N=7 (u halves down to 1); done in cycle 9, ans=1. Repeat with a=128, b=64: N=7, k=6, ans=64, done in cycle 9.
- start held high during busy with different operands (e.g. 50, 20): the result matches the first request only. A new start in the done cycle with a=21, b=14 is accepted and yields ans=7.
- rst asserted at cycle 3 of a=200, b=150:
  - next cycle busy=0, done=0, ans=0;
  - no done pulse appears afterwards;
  - a fresh start then completes with ans=50.
- WIDTH=16, randomised a/b against a reference Euclid model, 10k vectors:
  - ans is always correct;
  - done occurs within 2·WIDTH+2 cycles;
  - exactly one done pulse per accepted start.
